quad_decoder: RTL
=================

// Module: quad_decoder
// PURPOSE
//  Quadrature (A/B) decoder: produces the single-cycle increment/decrement pulses that drive the up/down counter.
//  Sits between the off-chip encoder pins and the counter; synchronises and optionally filters A/B.
//  Decodes Gray-code transitions into signed edges, then divides them down to one step per EDGES_PER_STEP edges.
//  Flags illegal transitions (both channels changing in one sample).
// PARAMETERS
//  SYNC_STAGES     2  synchroniser flops per input channel (>=2)
//  FILTER_LEN      3  consecutive identical samples needed to accept a level (used only with QDEC_FILTER_EN)
//  EDGES_PER_STEP  4  valid edges per output pulse; legal values 1, 2, 4 (x4, x2, x1 decode)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  enable      in   1  decode enable; low forces re-initialisation
//  quad_a      in   1  encoder channel A, asynchronous
//  quad_b      in   1  encoder channel B, asynchronous
//  err_clr     in   1  clears err_sticky (single-cycle strobe)
//  increment   out  1  one-cycle pulse: one forward step
//  decrement   out  1  one-cycle pulse: one reverse step
//  dir         out  1  direction of last valid edge: 1 = forward, 0 = reverse
//  step_err    out  1  one-cycle pulse on an illegal transition
//  err_sticky  out  1  set by step_err, cleared by err_clr
// BEHAVIOUR
//  - Reset: all outputs 0; synchronisers 0; state INIT; sub-count 0.
//  - AB = {a,b} after sync (and filter). Forward: 00->10->11->01->00. Reverse: the opposite order.
//  - States: INIT, TRACK. INIT: the first sample with enable=1 loads prev_ab, emits nothing, and goes to TRACK.
//    TRACK: each cycle, compare AB with prev_ab. Same = no edge. One bit changed = forward or reverse edge.
//    Both bits changed = illegal.
//  - Edge accumulator: signed sub in [-(E-1), E-1], where E = EDGES_PER_STEP.
//    Forward edge: if sub == E-1, pulse increment and set sub to 0; otherwise sub+1.
//    Reverse edge: if sub == -(E-1), pulse decrement and set sub to 0; otherwise sub-1.
//    E=1: every edge pulses. Reversal mid-step moves sub back toward 0, so there is no phantom step.
//  - Illegal edge: step_err pulses; err_sticky set; sub set to 0; prev_ab updated; no increment/decrement; dir unchanged.
//  - dir updates on every valid edge, in the same cycle as the sub update.
//  - increment and decrement are registered and mutually exclusive; never high for 2 consecutive cycles.
//    Only one edge is processed per cycle.
//  - Latency from a pin change to a pulse: SYNC_STAGES + 1 cycles, plus FILTER_LEN with the filter.
//  - enable=0: outputs increment/decrement/step_err forced 0; state set to INIT; sub set to 0;
//    err_sticky and dir held; synchronisers keep running.
//  - err_clr and a new illegal edge in the same cycle: err_sticky ends at 1 (set wins).
//  - Reset asserted mid-operation: immediate return to reset values. A pulse in flight is dropped.
// CONFIGURATION
//  - QDEC_FILTER_EN defined: each synced channel passes a glitch filter.
//    The output level changes only after FILTER_LEN consecutive equal samples that differ from the current output.
//    Filter output resets to 0; its counter resets to 0.
//  - QDEC_FILTER_EN undefined: the synced value is used directly; FILTER_LEN is ignored; no filter flops.
// STRUCTURE
//  - Package quad_pkg: the INIT/TRACK state encoding; AB phase constants PH_00/PH_10/PH_11/PH_01;
//    function qdec_dir(prev, cur) returning {valid, fwd, illegal}.
//  - Sub-module quad_input_filter (synchroniser + optional glitch filter), instantiated once per channel.
//  - Top level: state register, prev_ab, sub accumulator, output registers.
// TESTING (E=4, SYNC_STAGES=2, FILTER_LEN=3 unless noted)
//  - Reset release with A=B=1 held: no pulse and no step_err; the first edge 11->01 counts as a forward edge.
//  - Full forward cycle 00->10->11->01->00, each phase held 8 clk: exactly one increment, sent 3 cycles after the 4th edge;
//    dir=1.
//  - Forward 2 edges then reverse 2 edges: no increment/decrement; sub returns to 0; dir=0.
//  - E=1, 4 reverse edges: 4 decrement pulses, none adjacent; increment stays 0.
//  - Jump 00->11: step_err for 1 cycle, err_sticky=1; next err_clr clears it; err_clr together with a 2nd jump leaves it at 1.
//  - QDEC_FILTER_EN: a 2-cycle glitch on A gives no edge; a 3-cycle level is accepted, with latency 2+3+1 cycles.
//    Also drop enable mid-step, then re-enable: sub=0, state INIT, no pulse.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: FSM encoding, AB phase constants and the
// Gray-code transition classifier.
package quad_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } qdec_state_e;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef struct packed {
        logic valid;
        logic fwd;
        logic illegal;
    } qdec_edge_t;

    // Forward order is 00->10->11->01; the reverse successor is always the complement of the forward one.
    function automatic qdec_edge_t qdec_dir(input logic [1:0] prev, input logic [1:0] cur);
        qdec_edge_t r;
        logic [1:0] fwd_next;
        r = '0;
        case (prev)
            PH_00:   fwd_next = PH_10;
            PH_10:   fwd_next = PH_11;
            PH_11:   fwd_next = PH_01;
            default: fwd_next = PH_00;
        endcase
        if (cur == prev) begin
            r = '0;
        end else if (cur == fwd_next) begin
            r.valid = 1'b1;
            r.fwd   = 1'b1;
        end else if (cur == ~prev) begin
            r.illegal = 1'b1;
        end else begin
            r.valid = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-channel input conditioning: SYNC_STAGES-deep synchroniser, followed by a
// FILTER_LEN-sample glitch filter when QDEC_FILTER_EN is defined.
module quad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign dout_o = level_q;
`else
    assign dout_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder producing registered increment/decrement step pulses.
// Define QDEC_FILTER_EN to insert a glitch filter after each channel synchroniser.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 3,
    parameter int unsigned EDGES_PER_STEP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic quad_a,
    input  logic quad_b,
    input  logic err_clr,
    output logic increment,
    output logic decrement,
    output logic dir,
    output logic step_err,
    output logic err_sticky
);

    localparam int unsigned SUB_W = $clog2(EDGES_PER_STEP) + 2;
    localparam logic signed [SUB_W-1:0] SUB_MAX = SUB_W'(EDGES_PER_STEP - 1);
    localparam logic signed [SUB_W-1:0] SUB_MIN = -SUB_MAX;

    logic        a_s, b_s;
    logic [1:0]  ab;
    qdec_edge_t  ev;

    qdec_state_e             state_q, state_d;
    logic [1:0]              prev_ab_q, prev_ab_d;
    logic signed [SUB_W-1:0] sub_q, sub_d;
    logic                    inc_q, inc_d;
    logic                    dec_q, dec_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic                    sticky_q, sticky_d;

    quad_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .din_i  (quad_a),
        .dout_o (a_s)
    );

    quad_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .din_i  (quad_b),
        .dout_o (b_s)
    );

    assign ab = {a_s, b_s};
    assign ev = qdec_dir(prev_ab_q, ab);

    always_comb begin
        state_d   = state_q;
        prev_ab_d = prev_ab_q;
        sub_d     = sub_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        err_d     = 1'b0;
        dir_d     = dir_q;
        if (!enable) begin
            state_d = ST_INIT;
            sub_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    prev_ab_d = ab;
                    state_d   = ST_TRACK;
                end
                ST_TRACK: begin
                    if (ev.illegal) begin
                        err_d     = 1'b1;
                        sub_d     = '0;
                        prev_ab_d = ab;
                    end else if (ev.valid) begin
                        // A step-completing edge right after a pulse is left pending one cycle so pulses never abut.
                        if (ev.fwd && (sub_q == SUB_MAX)) begin
                            if (!(inc_q || dec_q)) begin
                                inc_d     = 1'b1;
                                sub_d     = '0;
                                prev_ab_d = ab;
                                dir_d     = 1'b1;
                            end
                        end else if (!ev.fwd && (sub_q == SUB_MIN)) begin
                            if (!(inc_q || dec_q)) begin
                                dec_d     = 1'b1;
                                sub_d     = '0;
                                prev_ab_d = ab;
                                dir_d     = 1'b0;
                            end
                        end else begin
                            sub_d     = ev.fwd ? (sub_q + SUB_W'(1)) : (sub_q - SUB_W'(1));
                            prev_ab_d = ab;
                            dir_d     = ev.fwd;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
        sticky_d = (sticky_q & ~err_clr) | err_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            prev_ab_q <= '0;
            sub_q     <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_ab_q <= prev_ab_d;
            sub_q     <= sub_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign increment  = inc_q;
    assign decrement  = dec_q;
    assign dir        = dir_q;
    assign step_err   = err_q;
    assign err_sticky = sticky_q;

endmodule
